arith_extend: RTL and testbench
===============================

# arith_extend

Parameterised, registered, multi-lane width extender for the arithmetic datapath. Each of `DEPTH` lanes takes an `IN_W`-bit value and produces an `OUT_W`-bit value, either sign-extended or zero-extended under one shared `sign` select. Outputs are registered, with one cycle of latency. The block sits between operand sources (immediates, sub-word loads) and the wider ALU/writeback path.

## Interface
Parameters:
- `IN_W`, default 16: input lane width in bits, ≥ 1.
- `OUT_W`, default 32: output lane width in bits, ≥ 1.
- `DEPTH`, default 1: number of independent lanes, ≥ 1.

Ports:
- One clock; reset is synchronous and active-high. Both are carried in the codebase control bundle `ctrl` (type `Util_Control_T(logic)`) and accessed as `Util_Control_Clock(ctrl)` and `Util_Control_Reset(ctrl)`.
- `ctrl`: input, control bundle.
  - Clock field: rising-edge clock.
  - Reset field: synchronous, active-high reset.
  - All other bundle fields are ignored.
- `in`: input, unpacked array `[DEPTH-1:0]` of `[IN_W-1:0]`. Lane inputs.
- `sign`: input, `Arith_SignedUnsigned_T(logic)`. `Arith_SignedUnsigned_Signed` selects sign extension; `Arith_SignedUnsigned_Unsigned` selects zero extension. Applies to all lanes.
- `out`: output, unpacked array `[DEPTH-1:0]` of `[OUT_W-1:0]`. Registered lane results.

## Operation
- Per lane `i`, compute the next value `ext[i]` combinationally:
  - OUT_W > IN_W, Signed: `{ {OUT_W-IN_W{in[i][IN_W-1]}}, in[i] }`.
  - OUT_W > IN_W, Unsigned: `{ {OUT_W-IN_W{1'b0}}, in[i] }`.
  - OUT_W == IN_W: `in[i]` unchanged, whatever the `sign` value.
  - OUT_W < IN_W: truncate to `in[i][OUT_W-1:0]`; `sign` has no effect.
- Lanes are fully independent; no cross-lane interaction.
- Any `sign` encoding other than Signed is treated as Unsigned.
- The block has no handshake, enable or stall. It captures `ext` on every clock edge.
- The block contains no state beyond the `DEPTH` output registers.

## Timing
- Registered: `out[i]` at edge N+1 equals `ext[i]` computed from `in` and `sign` sampled at edge N. Latency is 1 cycle; throughput is 1 result per lane per cycle.
- Reset (synchronous): at any rising edge with Reset=1, every `out[i]` becomes 0, whatever `in` and `sign` are.
- The first post-reset result appears at the first edge where Reset=0, and reflects the inputs at that edge.
- Reset mid-operation: output is 0 at the next edge and the in-flight value is discarded.
- Before the first clock edge, `out` is undefined. Benches must apply reset for ≥ 1 edge.
- `in` or `sign` changing between edges has no effect on `out` until the next edge. `out` is glitch-free, driven directly by flops.

## Test plan
Configuration IN_W=4, OUT_W=8, DEPTH=2, clock period 2 time units, unless stated otherwise.
- Reset: Reset=1 for one edge with in={0,0} and in={0xF,0xF} -> out[0]=out[1]=0x00 after the edge. Then release Reset with in={0,0} -> out stays 0x00.
- Signed extension: sign=Signed, in[0]=0xA, in[1]=0x5 -> one edge later out[0]=0xFA, out[1]=0x05. Next cycle in={0,0} -> out={0x00,0x00} one edge later.
- Unsigned extension: sign=Unsigned, in[0]=0xA, in[1]=0xF -> out[0]=0x0A, out[1]=0x0F after one edge.
- Boundary values, sign=Signed: in=0x8 -> 0xF8; in=0x7 -> 0x07; in=0xF -> 0xFF. Per-lane independence: in[0]=0x8, in[1]=0x7 -> out={0xF8,0x07} simultaneously.
- Latency and mid-operation reset: in[0]=0xA is applied for one cycle with Reset=1 asserted at that same edge -> out[0]=0x00 (not 0xFA). After release, a new input appears exactly one edge later.
- Parameter corners:
  - IN_W=OUT_W=8: in=0x80 -> out=0x80 for both sign values.
  - IN_W=8, OUT_W=4: in=0xA5 -> out=0x5.

Source files
------------

// File: rtl/arith_extend.sv
// ----------------------------------------------------------------------------
// arith_extend_pkg / arith_extend
//
// Purpose:
//   Registered, multi-lane width extender for the arithmetic datapath. Each of
//   DEPTH lanes widens (sign- or zero-extends) or truncates an IN_W-bit value
//   to OUT_W bits. One shared sign select applies to all lanes. Results are
//   registered with exactly one cycle of latency and no enable or stall.
//
// Parameters:
//   IN_W   - input lane width in bits  (>= 1)
//   OUT_W  - output lane width in bits (>= 1)
//   DEPTH  - number of independent lanes (>= 1)
//
// Ports:
//   ctrl   - control bundle: .clock (rising edge), .reset (sync, active-high)
//   in     - [DEPTH-1:0] lane inputs, IN_W bits each
//   sign   - ARITH_SIGNED selects sign extension, anything else zero extension
//   out    - [DEPTH-1:0] registered lane results, OUT_W bits each
// ----------------------------------------------------------------------------
package arith_extend_pkg;

    // Shared clock/reset bundle carried through the datapath.
    typedef struct packed {
        logic clock;
        logic reset;
    } util_control_t;

    // Signedness select for the extension.
    typedef enum logic {
        ARITH_UNSIGNED = 1'b0,
        ARITH_SIGNED   = 1'b1
    } arith_signed_unsigned_t;

endpackage

module arith_extend
    import arith_extend_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 1
) (
    input  util_control_t          ctrl,
    input  logic [IN_W-1:0]        in  [DEPTH-1:0],
    input  arith_signed_unsigned_t sign,
    output logic [OUT_W-1:0]       out [DEPTH-1:0]
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lane
            logic [OUT_W-1:0] out_d;
            logic [OUT_W-1:0] out_q;

            if (OUT_W > IN_W) begin : g_widen
                // Fill bit is the lane MSB only when sign extension is chosen;
                // every other select value yields zero fill.
                logic fill_bit;

                always_comb begin
                    fill_bit = (sign == ARITH_SIGNED) ? in[gi][IN_W-1] : 1'b0;
                    out_d    = {{(OUT_W-IN_W){fill_bit}}, in[gi]};
                end
            end else if (OUT_W == IN_W) begin : g_pass
                // Same width: value passes straight through; sign is irrelevant.
                logic unused_sign;
                assign unused_sign = sign;

                always_comb begin
                    out_d = in[gi];
                end
            end else begin : g_trunc
                // Narrowing: keep the low OUT_W bits; upper bits and sign
                // are deliberately dropped.
                logic unused_bits;
                assign unused_bits = ^{in[gi][IN_W-1:OUT_W], sign};

                always_comb begin
                    out_d = in[gi][OUT_W-1:0];
                end
            end

            // Output register: captures every edge, reset wins over data.
            always_ff @(posedge ctrl.clock) begin
                if (ctrl.reset) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign out[gi] = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_arith_extend.sv
// ----------------------------------------------------------------------------
// tb_arith_extend
//
// Purpose:
//   Directed, self-checking bench for arith_extend. The main instance uses
//   IN_W=4, OUT_W=8, DEPTH=2; two single-lane instances cover the equal-width
//   (8->8) and truncating (8->4) parameter corners. All share one control
//   bundle. Inputs change on the falling edge, outputs are sampled on the
//   following falling edge, one edge after capture.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_arith_extend;
    import arith_extend_pkg::*;

    logic          clk;
    logic          rst;
    util_control_t ctrl;

    assign ctrl.clock = clk;
    assign ctrl.reset = rst;

    // Main configuration: 4 -> 8, two lanes.
    logic [3:0]             in_m  [1:0];
    logic [7:0]             out_m [1:0];
    arith_signed_unsigned_t sign_m;

    // Equal-width corner: 8 -> 8, one lane.
    logic [7:0]             in_e  [0:0];
    logic [7:0]             out_e [0:0];

    // Truncating corner: 8 -> 4, one lane.
    logic [7:0]             in_t  [0:0];
    logic [3:0]             out_t [0:0];

    int n_compared;
    int n_mismatched;

    arith_extend #(.IN_W(4), .OUT_W(8), .DEPTH(2)) u_dut (
        .ctrl (ctrl),
        .in   (in_m),
        .sign (sign_m),
        .out  (out_m)
    );

    arith_extend #(.IN_W(8), .OUT_W(8), .DEPTH(1)) u_eq (
        .ctrl (ctrl),
        .in   (in_e),
        .sign (sign_m),
        .out  (out_e)
    );

    arith_extend #(.IN_W(8), .OUT_W(4), .DEPTH(1)) u_trunc (
        .ctrl (ctrl),
        .in   (in_t),
        .sign (sign_m),
        .out  (out_t)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got 0x%0h", tag, got);
        end
    endtask

    // Drive one vector on the falling edge, let one rising edge capture it,
    // then sample on the next falling edge.
    task automatic apply(input string tag, input logic r,
                         input arith_signed_unsigned_t s,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] eq_in, input logic [7:0] eq_exp,
                         input logic [7:0] tr_in, input logic [3:0] tr_exp);
        rst     = r;
        sign_m  = s;
        in_m[0] = a0;
        in_m[1] = a1;
        in_e[0] = eq_in;
        in_t[0] = tr_in;
        @(posedge clk);
        @(negedge clk);
        check_value({tag, " lane0"}, {24'h0, out_m[0]}, {24'h0, e0});
        check_value({tag, " lane1"}, {24'h0, out_m[1]}, {24'h0, e1});
        check_value({tag, " eq8"},   {24'h0, out_e[0]}, {24'h0, eq_exp});
        check_value({tag, " trunc"}, {28'h0, out_t[0]}, {28'h0, tr_exp});
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        sign_m       = ARITH_SIGNED;
        in_m[0]      = 4'h0;
        in_m[1]      = 4'h0;
        in_e[0]      = 8'h00;
        in_t[0]      = 8'h00;
        @(negedge clk);

        // Reset with zero and all-ones inputs, then release with zeros.
        apply("rst_zero",  1'b1, ARITH_SIGNED,   4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);
        apply("rst_ones",  1'b1, ARITH_SIGNED,   4'hF, 4'hF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 4'h0);
        apply("rel_zero",  1'b0, ARITH_SIGNED,   4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);

        // Signed extension, then back to zero.
        apply("sgn_a5",    1'b0, ARITH_SIGNED,   4'hA, 4'h5, 8'hFA, 8'h05, 8'h80, 8'h80, 8'hA5, 4'h5);
        apply("sgn_zero",  1'b0, ARITH_SIGNED,   4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0);

        // Unsigned extension; equal width ignores sign, truncation too.
        apply("uns_af",    1'b0, ARITH_UNSIGNED, 4'hA, 4'hF, 8'h0A, 8'h0F, 8'h80, 8'h80, 8'hA5, 4'h5);

        // Boundary values and per-lane independence.
        apply("sgn_87",    1'b0, ARITH_SIGNED,   4'h8, 4'h7, 8'hF8, 8'h07, 8'h7F, 8'h7F, 8'h3C, 4'hC);
        apply("sgn_ff",    1'b0, ARITH_SIGNED,   4'hF, 4'hF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF);
        apply("uns_88",    1'b0, ARITH_UNSIGNED, 4'h8, 4'h8, 8'h08, 8'h08, 8'h01, 8'h01, 8'h10, 4'h0);

        // Build up a non-zero state, then reset at the edge carrying 0xA.
        apply("pre_rst",   1'b0, ARITH_SIGNED,   4'h7, 4'h7, 8'h07, 8'h07, 8'h55, 8'h55, 8'h5A, 4'hA);
        apply("mid_rst",   1'b1, ARITH_SIGNED,   4'hA, 4'hA, 8'h00, 8'h00, 8'h80, 8'h00, 8'hA5, 4'h0);
        apply("post_rst",  1'b0, ARITH_SIGNED,   4'hA, 4'h8, 8'hFA, 8'hF8, 8'hC3, 8'hC3, 8'hC3, 4'h3);

        // Changing inputs between edges must not disturb the outputs.
        in_m[0] = 4'h3;
        in_m[1] = 4'h3;
        sign_m  = ARITH_UNSIGNED;
        in_e[0] = 8'h11;
        in_t[0] = 8'h22;
        #0.5;
        check_value("hold lane0", {24'h0, out_m[0]}, 32'h0000_00FA);
        check_value("hold lane1", {24'h0, out_m[1]}, 32'h0000_00F8);
        check_value("hold eq8",   {24'h0, out_e[0]}, 32'h0000_00C3);
        @(negedge clk);
        check_value("next lane0", {24'h0, out_m[0]}, 32'h0000_0003);
        check_value("next trunc", {28'h0, out_t[0]}, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
